// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, burst-locked sharing of one async-FIFO write port
//            among NUM_REQ requesters in the write clock domain.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_wclk,
    input  logic                          i_wrst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_wfull,
    output logic                          o_winc,
    output logic [DATA_WIDTH-1:0]         o_wdata,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int BCW  = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   gidx_q;
    logic [IDXW-1:0]   lp_q;
    logic [BCW-1:0]    bc_q;

    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
    logic                  w_busy;
    logic                  w_acc;
    logic                  w_rel;
    logic [IDXW-1:0]       w_base;
    logic [IDXW-1:0]       w_idx;
    logic [IDXW-1:0]       w_pick;
    logic                  w_found;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_words
            assign w_words[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_busy = (state_q == S_GRANT);
    // Reset gates the strobe so a burst interrupted by reset never writes.
    assign w_acc  = w_busy && i_req[gidx_q] && !i_wfull && !i_wrst;
    assign w_rel  = w_busy && ((w_acc && (bc_q == BCW'(MAX_BURST - 1))) || !i_req[gidx_q]);

    // Rotation starts after the requester just released, so the same-edge
    // re-arbitration already sees the updated last-served pointer.
    assign w_base = w_rel ? gidx_q : lp_q;

    always_comb begin
        w_idx   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        // Descending scan: the last hit is the nearest requester after w_base.
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = IDXW'((int'(w_base) + i) % NUM_REQ);
            if (i_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_wclk) begin
        if (i_wrst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            lp_q    <= IDXW'(NUM_REQ - 1);
            bc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        state_q <= S_GRANT;
                        gidx_q  <= w_pick;
                        bc_q    <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_rel) begin
                        lp_q <= gidx_q;
                        bc_q <= '0;
                        if (w_found) begin
                            gidx_q <= w_pick;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (w_acc) begin
                        bc_q <= bc_q + BCW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ack   = '0;
        o_grant = '0;
        o_wdata = '0;
        if (w_busy) begin
            o_grant[gidx_q] = 1'b1;
            o_wdata         = w_words[gidx_q];
        end
        if (w_acc) begin
            o_ack[gidx_q] = 1'b1;
        end
    end

    assign o_winc = w_acc;
    assign o_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed and model-checked stimulus for fifo_wr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        busy;

    int n_vec;
    int n_err;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .i_wclk  (clk),
        .i_wrst  (rst),
        .i_req   (req),
        .i_data  (data),
        .o_ack   (ack),
        .i_wfull (full),
        .o_winc  (winc),
        .o_wdata (wdata),
        .o_grant (grant),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        to_next();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] word(input int k);
        return data[k*8 +: 8];
    endfunction

    function automatic int mpick(input int base, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    logic [5:0] cnt [4];
    logic       m_busy;
    int         m_g, m_lp, m_bc, p, acks;
    logic       e_acc;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'hF;
        full  = 1'b0;
        data  = 32'h44332211;

        // Reset held two cycles with every requester asking.
        to_next();
        repeat (2) begin
            to_neg();
            check("rst_winc", {31'd0, winc}, 32'd0);
            check("rst_grant", {28'd0, grant}, 32'd0);
            to_next();
        end
        rst = 1'b0;
        to_neg();
        check("idle_grant", {28'd0, grant}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_wdata", {24'd0, wdata}, 32'd0);
        to_next();

        // Rotation: four bursts of four, no bubbles.
        for (int n = 0; n < 16; n++) begin
            to_neg();
            check("rot_grant", {28'd0, grant}, 32'(1 << (n / 4)));
            check("rot_ack", {28'd0, ack}, 32'(1 << (n / 4)));
            check("rot_winc", {31'd0, winc}, 32'd1);
            check("rot_wdata", {24'd0, wdata}, {24'd0, word(n / 4)});
            to_next();
        end
        to_neg();
        check("rot_wrap", {28'd0, grant}, 32'h1);
        to_next();

        // Full stall mid-burst on requester 2.
        do_reset(4'b1100);
        to_neg();
        check("st_idle", {28'd0, grant}, 32'd0);
        to_next();
        repeat (2) begin
            to_neg();
            check("st_beat_a", {28'd0, grant}, 32'h4);
            check("st_winc_a", {31'd0, winc}, 32'd1);
            to_next();
        end
        full = 1'b1;
        repeat (5) begin
            to_neg();
            check("st_hold_winc", {31'd0, winc}, 32'd0);
            check("st_hold_ack", {28'd0, ack}, 32'd0);
            check("st_hold_grant", {28'd0, grant}, 32'h4);
            to_next();
        end
        full = 1'b0;
        repeat (2) begin
            to_neg();
            check("st_beat_b", {28'd0, grant}, 32'h4);
            check("st_wdata_b", {24'd0, wdata}, 32'h33);
            check("st_winc_b", {31'd0, winc}, 32'd1);
            to_next();
        end
        to_neg();
        check("st_rot_grant", {28'd0, grant}, 32'h8);
        check("st_rot_wdata", {24'd0, wdata}, 32'h44);
        check("st_rot_winc", {31'd0, winc}, 32'd1);
        to_next();

        // Early drop, then pointer-driven choice between 1 and 3.
        do_reset(4'b0010);
        to_neg();
        check("ed_idle", {28'd0, grant}, 32'd0);
        to_next();
        repeat (2) begin
            to_neg();
            check("ed_beat", {28'd0, ack}, 32'h2);
            to_next();
        end
        req = 4'b0000;
        to_neg();
        check("ed_drop_grant", {28'd0, grant}, 32'h2);
        check("ed_drop_winc", {31'd0, winc}, 32'd0);
        to_next();
        req = 4'b1000;
        to_neg();
        check("ed_idle2", {31'd0, busy}, 32'd0);
        to_next();
        to_neg();
        check("ed_r3_grant", {28'd0, grant}, 32'h8);
        check("ed_r3_wdata", {24'd0, wdata}, 32'h44);
        to_next();
        req = 4'b0000;
        to_neg();
        check("ed_r3_drop", {31'd0, winc}, 32'd0);
        to_next();
        req = 4'b1010;
        to_neg();
        check("ed_idle3", {28'd0, grant}, 32'd0);
        to_next();
        to_neg();
        check("ed_pick1", {28'd0, grant}, 32'h2);
        check("ed_pick1_wd", {24'd0, wdata}, 32'h22);
        to_next();

        // Single requester: continuous writes across burst boundaries.
        do_reset(4'b0001);
        acks = 0;
        to_neg();
        check("sr_idle", {28'd0, grant}, 32'd0);
        to_next();
        for (int n = 0; n < 10; n++) begin
            to_neg();
            check("sr_winc", {31'd0, winc}, 32'd1);
            check("sr_grant", {28'd0, grant}, 32'h1);
            if (ack[0]) acks++;
            to_next();
        end
        check("sr_acks", 32'(acks), 32'd10);

        // Reset asserted in the middle of a burst.
        rst = 1'b1;
        to_neg();
        check("mr_winc", {31'd0, winc}, 32'd0);
        to_next();
        rst = 1'b0;
        to_neg();
        check("mr_winc2", {31'd0, winc}, 32'd0);
        check("mr_grant", {28'd0, grant}, 32'd0);
        to_next();

        // Random traffic against a behavioural model.
        do_reset(4'b0000);
        m_busy = 1'b0;
        m_g    = 0;
        m_lp   = 3;
        m_bc   = 0;
        for (int k = 0; k < 4; k++) cnt[k] = '0;
        for (int n = 0; n < 3000; n++) begin
            req  = 4'($urandom);
            full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) data[k*8 +: 8] = {2'(k), cnt[k]};
            e_acc = m_busy && req[m_g] && !full;
            to_neg();
            check("rnd_winc", {31'd0, winc}, {31'd0, e_acc});
            check("rnd_ack", {28'd0, ack}, e_acc ? 32'(1 << m_g) : 32'd0);
            check("rnd_grant", {28'd0, grant}, m_busy ? 32'(1 << m_g) : 32'd0);
            check("rnd_wdata", {24'd0, wdata}, m_busy ? {24'd0, word(m_g)} : 32'd0);
            if (e_acc) cnt[m_g] = cnt[m_g] + 6'd1;
            if (m_busy) begin
                if ((e_acc && m_bc == 3) || !req[m_g]) begin
                    m_lp = m_g;
                    m_bc = 0;
                    p = mpick(m_lp, req);
                    if (p >= 0) m_g = p;
                    else m_busy = 1'b0;
                end else if (e_acc) begin
                    m_bc++;
                end
            end else if (req != 4'd0) begin
                m_busy = 1'b1;
                m_g    = mpick(m_lp, req);
                m_bc   = 0;
            end
            to_next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
